// File: rtl/shift_seq8_if.sv
// shift_seq8_if: command/result handshake bundle for the iterative shifter.
//   in_valid/in_ready : command handshake (din, shamt, dir, mode)
//   out_valid/out_ready : result handshake (dout, cout)
//   busy : shifter is in SHIFT or DONE
//   modport slave is used by the shifter, modport master by its driver.
interface shift_seq8_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   din;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   dout;
    logic               cout;
    logic               busy;

    modport slave (
        input  in_valid, din, shamt, dir, mode, out_ready,
        output in_ready, out_valid, dout, cout, busy
    );

    modport master (
        output in_valid, din, shamt, dir, mode, out_ready,
        input  in_ready, out_valid, dout, cout, busy
    );
endinterface

// File: rtl/shift_seq8.sv
// shift_seq8: iterative shifter, one bit position per clock, with valid/ready ports.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : shift_seq8_if.slave (command in, result out, busy)
module shift_seq8 #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input logic        clk,
    input logic        rst,
    shift_seq8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   d, step_d;
    logic               c, step_c;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_q;
    logic [1:0]         mode_q;
    logic               accept;

    assign accept        = bus.in_valid && state == IDLE;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.dout      = d;
    assign bus.cout      = c;

    // Single-bit step; mode 11 falls through to logical, and left arithmetic equals left logical.
    always_comb begin
        step_d = dir_q ? {d[WIDTH-2:0], mode_q == 2'b10 ? d[WIDTH-1] : 1'b0}
                       : {mode_q == 2'b10 ? d[0] : mode_q == 2'b01 ? d[WIDTH-1] : 1'b0, d[WIDTH-1:1]};
        step_c = dir_q ? d[WIDTH-1] : d[0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (bus.shamt == '0 ? DONE : SHIFT) : IDLE;
            SHIFT:   state_nxt = cnt <= SHAMT_W'(1) ? DONE : SHIFT;
            DONE:    state_nxt = bus.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d      <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            mode_q <= 2'b00;
        end else if (accept) begin
            d      <= bus.din;
            c      <= 1'b0;
            cnt    <= bus.shamt;
            dir_q  <= bus.dir;
            mode_q <= bus.mode;
        end else if (state == SHIFT) begin
            d <= step_d;
            c <= step_c;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: scoreboard bench for shift_seq8 (expected results queued at accept, checked at out_valid).
module tb_shift_seq8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       c;
        int         s;
    } exp_t;

    exp_t q[$];

    shift_seq8_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

    shift_seq8 #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-shift reference built from shift operators, independent of the per-step datapath.
    function automatic exp_t model(input logic [7:0] din, input int s, input logic dr, input logic [1:0] m);
        exp_t        e;
        logic [15:0] t;
        e.s = s;
        e.d = din;
        e.c = 1'b0;
        if (s != 0) begin
            if (!dr) begin
                t   = {din, din} >> s;
                e.d = m == 2'b10 ? t[7:0] : m == 2'b01 ? 8'($signed(din) >>> s) : din >> s;
                e.c = din[s-1];
            end else begin
                t   = {din, din} << s;
                e.d = m == 2'b10 ? t[15:8] : din << s;
                e.c = din[8-s];
            end
        end
        return e;
    endfunction

    // Issue one command, wait for its result, compare, then optionally stall the output with hold cycles.
    task automatic do_op(input logic [7:0] din, input int s, input logic dr, input logic [1:0] m, input int hold);
        int         cyc;
        exp_t       e;
        logic [7:0] hd;
        logic       hc;
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.din      = din;
        bus.shamt    = 3'(s);
        bus.dir      = dr;
        bus.mode     = m;
        q.push_back(model(din, s, dr, m));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.din      = ~din;
        bus.shamt    = 3'(7 - s);
        bus.dir      = ~dr;
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            if (!bus.busy || bus.in_ready)
                check("busy_in_shift", {bus.busy, bus.in_ready}, 2'b10);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 1 + s);
        check("busy_done", {bus.busy, bus.in_ready}, 2'b10);
        e = q.pop_front();
        check("dout", bus.dout, e.d);
        check("cout", bus.cout, e.c);
        hd = bus.dout;
        hc = bus.cout;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.din      = 8'h33;
            bus.shamt    = 3'd0;
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_ready", bus.in_ready, 0);
            check("hold_data", {bus.cout, bus.dout}, {hc, hd});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("back_to_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    endtask

    initial begin
        int pulses;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.shamt     = '0;
        bus.dir       = 1'b0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state", {bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.dout}, {4'b1000, 8'h00});

        do_op(8'hB1, 3, 1'b0, 2'b00, 0);
        do_op(8'hB1, 2, 1'b0, 2'b01, 0);
        do_op(8'h7F, 7, 1'b0, 2'b01, 0);
        do_op(8'h81, 1, 1'b1, 2'b10, 0);
        do_op(8'hFF, 7, 1'b1, 2'b00, 0);
        do_op(8'hFF, 7, 1'b1, 2'b11, 0);
        do_op(8'h5A, 0, 1'b0, 2'b00, 0);
        do_op(8'hC5, 4, 1'b0, 2'b10, 5);
        do_op(8'h33, 2, 1'b1, 2'b01, 0);
        for (int i = 0; i < 24; i++)
            do_op(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), 0);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.din      = 8'hB1;
        bus.shamt    = 3'd5;
        bus.dir      = 1'b0;
        bus.mode     = 2'b00;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.din      = 8'h44;
        bus.shamt    = 3'd0;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_mid", {bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.dout}, {4'b1000, 8'h00});
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy)
                pulses++;
        end
        check("rst_no_result", pulses, 0);
        check("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
